// File: rtl/modq_pkg.sv
// modq_pkg: shared modulus parameters and accumulator FSM states.
package modq_pkg;
  localparam int Q  = 1693;
  localparam int W  = 11;
  localparam int CW = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;
endpackage

// File: rtl/mod_add_q.sv
// mod_add_q: (a + b) mod Q by one conditional subtract; needs a + b < 2Q.
module mod_add_q #(
  parameter int Q = 1693,
  parameter int W = 11
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] r_o
);
  localparam logic [W:0] QV = (W+1)'(Q);
  logic [W:0] s;
  assign s   = {1'b0, a_i} + {1'b0, b_i};
  assign r_o = W'(s >= QV ? s - QV : s);
endmodule

// File: rtl/modacc_1693.sv
// modacc_1693: frame accumulator summing residues mod Q, with term count and
// out-of-range flag, valid/ready handshakes on both input and output.
module modacc_1693
  import modq_pkg::*;
#(
  parameter int Q  = modq_pkg::Q,
  parameter int W  = modq_pkg::W,
  parameter int CW = modq_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  din_a,
  input  logic          din_valid,
  input  logic          din_last,
  output logic          din_ready,
  output logic [W-1:0]  dout_r,
  output logic [CW-1:0] dout_cnt,
  output logic          dout_err,
  output logic          dout_valid,
  input  logic          dout_ready
);
  state_t        state_q;
  logic [W-1:0]  acc_q, acc_d, t;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  // Pre-reduction shares the adder with b tied low; a changed value means din_a >= Q.
  mod_add_q #(.Q(Q), .W(W)) u_pre (.a_i(din_a), .b_i('0), .r_o(t));
  mod_add_q #(.Q(Q), .W(W)) u_acc (.a_i(acc_q), .b_i(t), .r_o(acc_d));
  always_comb begin
    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    err_d = err_q | (t != din_a);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (state_q == OUT) begin
      if (dout_ready) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
    end else if (din_valid) begin
      state_q <= din_last ? OUT : ACC;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign din_ready  = state_q != OUT;
  assign dout_valid = state_q == OUT;
  assign dout_r     = acc_q;
  assign dout_cnt   = cnt_q;
  assign dout_err   = err_q;
endmodule

// File: tb/tb_modacc_1693.sv
// tb_modacc_1693: randomized and directed checks against a sum-mod-Q model.
module tb_modacc_1693;
  localparam int Q  = 1693;
  localparam int W  = 11;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] din_a = '0;
  logic din_valid = 1'b0, din_last = 1'b0, dout_ready = 1'b0;
  logic din_ready, dout_valid, dout_err;
  logic [W-1:0] dout_r;
  logic [CW-1:0] dout_cnt;
  logic s_din_ready, s_dout_valid, s_dout_err;
  logic [W-1:0] s_dout_r;
  logic [3:0] s_dout_cnt;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  modacc_1693 #(.Q(Q), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .din_a(din_a), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready), .dout_r(dout_r),
    .dout_cnt(dout_cnt), .dout_err(dout_err), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  modacc_1693 #(.Q(Q), .W(W), .CW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .din_a(din_a), .din_valid(din_valid),
    .din_last(din_last), .din_ready(s_din_ready), .dout_r(s_dout_r),
    .dout_cnt(s_dout_cnt), .dout_err(s_dout_err), .dout_valid(s_dout_valid),
    .dout_ready(dout_ready)
  );

  task automatic send(input logic [W-1:0] a, input bit last);
    @(negedge clk);
    din_a = a;
    din_last = last;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic xfer();
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", dout_valid); end
    n_checks++; if (dout_r !== '0) begin n_fail++; $display("FAIL reset_r: got %0d expected 0", dout_r); end
    n_checks++; if (dout_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dout_cnt); end
    n_checks++; if (dout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", dout_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0d expected 1", din_ready); end
  endtask

  task automatic test_directed();
    int terms [5][3] = '{'{1692, 1, 0}, '{1000, 1000, 1000}, '{1692, 0, 0}, '{2047, 0, 0}, '{5, 0, 0}};
    int len [5] = '{2, 3, 1, 1, 1};
    int er [5] = '{0, 1307, 1692, 354, 5};
    int ee [5] = '{0, 0, 0, 1, 0};
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < len[f]; k++) send(W'(terms[f][k]), k == len[f] - 1);
      @(negedge clk);
      n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %0d expected 1", f, dout_valid); end
      n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL dir%0d_ready: got %0d expected 0", f, din_ready); end
      n_checks++; if (dout_r !== W'(er[f])) begin n_fail++; $display("FAIL dir%0d_r: got %0d expected %0d", f, dout_r, er[f]); end
      n_checks++; if (dout_cnt !== CW'(len[f])) begin n_fail++; $display("FAIL dir%0d_cnt: got %0d expected %0d", f, dout_cnt, len[f]); end
      n_checks++; if (dout_err !== ee[f][0]) begin n_fail++; $display("FAIL dir%0d_err: got %0d expected %0d", f, dout_err, ee[f]); end
      xfer();
      @(negedge clk);
      n_checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_idle: got valid=%0d ready=%0d expected 0/1", f, dout_valid, din_ready); end
      n_checks++; if (dout_r !== '0 || dout_cnt !== '0 || dout_err !== 1'b0) begin n_fail++; $display("FAIL dir%0d_clear: got r=%0d cnt=%0d err=%0d expected 0", f, dout_r, dout_cnt, dout_err); end
    end
  endtask

  task automatic test_backpressure();
    send(W'(7), 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (dout_valid !== 1'b1 || dout_r !== W'(7) || din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d: got valid=%0d r=%0d ready=%0d expected 1/7/0", c, dout_valid, dout_r, din_ready); end
      din_a = W'($urandom_range(0, 2047));
      din_last = 1'b1;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din_last = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (dout_r !== W'(7) || dout_cnt !== CW'(1) || dout_err !== 1'b0) begin n_fail++; $display("FAIL bp_final: got r=%0d cnt=%0d err=%0d expected 7/1/0", dout_r, dout_cnt, dout_err); end
    xfer();
    @(negedge clk);
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_xfer: got %0d expected 0", dout_valid); end
  endtask

  task automatic test_midframe_reset();
    send(W'(10), 1'b0);
    send(W'(20), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (dout_r !== '0 || dout_cnt !== '0 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst: got r=%0d cnt=%0d valid=%0d ready=%0d expected 0/0/0/1", dout_r, dout_cnt, dout_valid, din_ready); end
    send(W'(5), 1'b1);
    @(negedge clk);
    n_checks++; if (dout_valid !== 1'b1 || dout_r !== W'(5) || dout_cnt !== CW'(1)) begin n_fail++; $display("FAIL mid_next: got valid=%0d r=%0d cnt=%0d expected 1/5/1", dout_valid, dout_r, dout_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (dout_valid !== 1'b0 || dout_r !== '0) begin n_fail++; $display("FAIL out_rst: got valid=%0d r=%0d expected 0/0", dout_valid, dout_r); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) send(W'(100), k == 19);
    @(negedge clk);
    n_checks++; if (dout_cnt !== CW'(20) || dout_r !== W'(2000 % Q)) begin n_fail++; $display("FAIL sat_wide: got cnt=%0d r=%0d expected 20/%0d", dout_cnt, dout_r, 2000 % Q); end
    n_checks++; if (s_dout_valid !== 1'b1 || s_dout_cnt !== 4'd15 || s_dout_r !== W'(2000 % Q)) begin n_fail++; $display("FAIL sat_narrow: got valid=%0d cnt=%0d r=%0d expected 1/15/%0d", s_dout_valid, s_dout_cnt, s_dout_r, 2000 % Q); end
    xfer();
    @(negedge clk);
    n_checks++; if (s_din_ready !== 1'b1 || s_dout_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clear: got ready=%0d cnt=%0d expected 1/0", s_din_ready, s_dout_cnt); end
  endtask

  task automatic test_random();
    int edges [4] = '{0, Q - 1, Q, 2047};
    for (int f = 0; f < 40; f++) begin
      int n;
      int a;
      int stall;
      longint sum;
      bit err;
      n = $urandom_range(1, 6);
      sum = 0;
      err = 1'b0;
      for (int k = 0; k < n; k++) begin
        a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom_range(0, 2047);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sum += a;
        err |= (a >= Q);
        send(W'(a), k == n - 1);
      end
      @(negedge clk);
      n_checks++; if (dout_valid !== 1'b1 || dout_r !== W'(sum % Q) || dout_cnt !== CW'(n) || dout_err !== err) begin n_fail++; $display("FAIL rnd%0d: got valid=%0d r=%0d cnt=%0d err=%0d expected 1/%0d/%0d/%0d", f, dout_valid, dout_r, dout_cnt, dout_err, sum % Q, n, err); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b1 || dout_r !== W'(sum % Q)) begin n_fail++; $display("FAIL rnd%0d_stall: got valid=%0d r=%0d expected 1/%0d", f, dout_valid, dout_r, sum % Q); end
      end
      xfer();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_midframe_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
